// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-in / serial-out handshake bundle for uart_tx.
//               master = byte producer (CPU/MMIO store path)
//               slave  = transmitter
//   tx_data  [WIDTH] byte to send, sampled only on accept
//   tx_start         send request
//   tx_ready         transmitter idle and able to accept
//   tx_busy          frame in progress (inverse of tx_ready)
//   tx_done          single-cycle pulse in the last cycle of the stop bit
//   tx               serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic             tx_ready;
  logic             tx_busy;
  logic             tx_done;
  logic             tx;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx_busy, tx_done, tx
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx_busy, tx_done, tx
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Serial transmitter, 8N1 by default. Accepts one parallel
//               byte per frame and shifts it out LSB-first, each bit held
//               CLKS_PER_BIT clocks. All outputs are registered.
//               Optional build macro UART_PARITY_EN inserts an even-parity
//               bit between the last data bit and the stop bit.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - uart_tx_if.slave (tx_data, tx_start, tx_ready,
//                      tx_busy, tx_done, tx)
// Parameters  : CLKS_PER_BIT (>= 2), WIDTH (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WIDTH        = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
  logic [WIDTH-1:0]  r_shift,  w_shift_nxt;
  logic              r_tx,     w_tx_nxt;
  logic              r_ready,  w_ready_nxt;
  logic              r_busy;
  logic              r_done,   w_done_nxt;
  logic              w_baud_end;
  logic [CNT_W-1:0]  w_cnt_inc;
`ifdef UART_PARITY_EN
  logic              r_parity, w_parity_nxt;
`endif

  assign w_baud_end = (r_cnt == C_CNT_LAST);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= ~w_ready_nxt;
      r_done   <= w_done_nxt;
`ifdef UART_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  // Every branch computes the value each output must show in the *next*
  // cycle, so the registered outputs line up with the FSM state.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_ready_nxt  = r_ready;
    w_done_nxt   = 1'b0;
`ifdef UART_PARITY_EN
    w_parity_nxt = r_parity;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (bus.tx_start && r_ready) begin
          w_state_nxt  = S_START;
          w_cnt_nxt    = '0;
          w_shift_nxt  = bus.tx_data;
          w_tx_nxt     = 1'b0;
          w_ready_nxt  = 1'b0;
`ifdef UART_PARITY_EN
          w_parity_nxt = ^bus.tx_data;
`endif
        end
      end

      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == C_IDX_LAST) begin
            w_idx_nxt   = '0;
`ifdef UART_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            // r_shift[1] is the bit that lands in position 0 after this shift
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_end) begin
          w_cnt_nxt = '0;
          if (bus.tx_start) begin
            // A request pending at the end of the stop bit is taken at this
            // edge so the next start bit follows with no idle gap; tx_ready
            // stays low across the chained frames.
            w_state_nxt  = S_START;
            w_shift_nxt  = bus.tx_data;
            w_tx_nxt     = 1'b0;
`ifdef UART_PARITY_EN
            w_parity_nxt = ^bus.tx_data;
`endif
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          // Raise done so that it is visible in the final stop-bit cycle.
          if (r_cnt == C_CNT_PRE) begin
            w_done_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = r_ready;
  assign bus.tx_busy  = r_busy;
  assign bus.tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx at CLKS_PER_BIT=4, WIDTH=8.
//               Inputs are driven and outputs sampled on the falling edge.
//               Builds with or without UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int W   = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.WIDTH(W)) bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // frame: 10-bit line pattern in send order (bit0 = start bit) for 8N1
  // par  : expected even-parity bit
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " tx"},    32'(bus.tx),       32'd1);
    chk({tag, " ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, " busy"},  32'(bus.tx_busy),  32'd0);
    chk({tag, " done"},  32'(bus.tx_done),  32'd0);
  endtask

  function automatic logic [10:0] mk(input logic [9:0] f, input logic p);
`ifdef UART_PARITY_EN
    mk = {1'b1, p, f[8:0]};
`else
    mk = {1'b0, f};
    if (p) mk = {1'b0, f};
`endif
  endfunction

  // Entered at the falling edge of cycle 1 of a frame; checks ncyc cycles
  // and leaves at the falling edge of the following cycle.
  task automatic run_frame(input logic [10:0] expb, input int ncyc, input bit full,
                           input int poke_cyc, input logic [7:0] poke_data);
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("tx c%0d", c),    32'(bus.tx),       32'(expb[(c-1)/CPB]));
      chk($sformatf("done c%0d", c),  32'(bus.tx_done),  32'(full && (c == FL)));
      chk($sformatf("ready c%0d", c), 32'(bus.tx_ready), 32'd0);
      chk($sformatf("busy c%0d", c),  32'(bus.tx_busy),  32'd1);
      if (poke_cyc > 0 && c == poke_cyc) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = poke_data;
      end else if (poke_cyc > 0 && c == poke_cyc + 1) begin
        bus.tx_start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h00, 10'h200, 1'b0};
    vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[3] = '{8'h01, 10'h202, 1'b1};
    vecs[4] = '{8'h80, 10'h300, 1'b1};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    vecs[6] = '{8'h3C, 10'h278, 1'b0};

    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    rst          = 1'b1;
    @(negedge clk);

    // Reset for 3 cycles with tx_start asserted: must stay idle.
    bus.tx_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    bus.tx_start = 1'b0;
    rst          = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Single frames from the vector table.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data);
      run_frame(mk(vecs[i].frame, vecs[i].par), FL, 1'b1, 0, 8'h00);
      check_idle($sformatf("post v%0d", i));
    end

    // Back-to-back with tx_start held: 0x00 then 0xFF, no gap.
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_data  = 8'hFF;
    run_frame(mk(10'h200, 1'b0), FL, 1'b1, 0, 8'h00);
    bus.tx_start = 1'b0;
    run_frame(mk(10'h3FE, 1'b0), FL, 1'b1, 0, 8'h00);
    check_idle("b2b end");

    // Request pulsed mid-frame with different data: ignored.
    send(8'hA5);
    run_frame(mk(10'h34A, 1'b0), FL, 1'b1, 10, 8'h5A);
    repeat (5) begin
      check_idle("no requeue");
      @(negedge clk);
    end

    // Reset during data bit 3 of 0x3C (cycles 17..20 of the frame).
    send(8'h3C);
    run_frame(mk(10'h278, 1'b0), 18, 1'b0, 0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst mid");
    repeat (FL) begin
      @(negedge clk);
      check_idle("post rst");
    end
    send(8'h3C);
    run_frame(mk(10'h278, 1'b0), FL, 1'b1, 0, 8'h00);
    check_idle("fresh 3C");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
